trash_cpu: RTL and testbench
============================

# trash_cpu

Parametrised successor to the 4-register toy processor. It holds a loadable program store, a register file, a data memory and an integrated ALU, and executes one 16-bit instruction per clock. Programming and execution are separate modes selected by a `run` input. The block sits directly behind the top-level pin wrapper: `prog_data` is fed from `{ui_in, uio_in}`, and `out_data` drives `uo_out`.

## Interface
- `DW`, default 8: data/register width, 4..16.
- `NREGS`, default 4: register count, power of 2, 2..16.
- `PDEPTH`, default 8: program words, power of 2, 2..16.
- `MDEPTH`, default 16: data memory words, power of 2, 2..256.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `run` in 1: 0 = programming mode, 1 = execution mode.
- `prog_valid` in 1: in programming mode, write `prog_data` this cycle.
- `prog_data` in 16: instruction word to load.
- `out_data` out DW: last value emitted by an OUT instruction.
- `out_valid` out 1: one-cycle pulse when `out_data` updates.
- `pc` out log2(PDEPTH): current program counter.
- `halted` out 1: high while in the HALT state.

## Operation
- Instruction format: op = [15:12], A = [11:8], B = [7:4], C = [3:0], imm = [7:0].
- Register fields use their low log2(NREGS) bits. Memory addresses are imm mod MDEPTH. Jump targets are C mod PDEPTH.
- Ops:
  - 0 NOP.
  - 1 LDI: R[A] ← imm, zero-extended (truncated to DW when DW < 8).
  - 2 ALU: R[A] ← R[A] op(C) R[B].
  - 3 ST: M[imm] ← R[A].
  - 4 LD: R[A] ← M[imm].
  - 5 JMP: pc ← C.
  - 6 JEQ: if R[A] == R[B] then pc ← C, else pc + 1.
  - 7 JNE: inverse of JEQ.
  - 8 OUT: out_data ← R[A], out_valid pulses.
  - 9–E: NOP.
  - F HALT.
- ALU ops by C, results truncated to DW, unsigned:
  - 0 add, 1 sub, 2 mul (low DW bits), 3 div, 4 mod.
  - 5 and, 6 or, 7 xor, 8 not A, 9 shl 1, A shr 1, B inc, C dec.
  - D min, E max, F pass B.
- FSM states:
  - LOAD: entered on reset or whenever `run` = 0.
    - Each `prog_valid` cycle writes P[lptr] ← `prog_data`, then lptr increments and wraps at PDEPTH.
    - `pc` is held at 0 and `halted` = 0.
  - LOAD → RUN on the first edge with `run` = 1. That same edge executes P[0]; there is no idle start cycle.
  - RUN: executes P[pc] every edge. Non-jump ops do pc ← pc + 1, wrapping PDEPTH-1 → 0.
  - RUN → HALT when HALT executes. `pc` stays on the HALT address.
  - HALT: nothing changes, `halted` = 1.
  - RUN/HALT → LOAD on any edge with `run` = 0. On that edge: pc ← 0, lptr ← 0, `halted` ← 0.
- Registers and data memory are not cleared on a mode change, only by reset. `prog_valid` is ignored in RUN and HALT.
- Reset values: all outputs are 0, state = LOAD, lptr = 0, all registers = 0, data memory = 0, program store = 0 (all NOP).

## Timing
- Single-cycle execution. A result written at edge N is readable by the instruction executed at edge N+1, with no hazards.
- OUT at edge N: `out_data` and `out_valid` are valid from N until N+1. `out_valid` drops at N+1 unless the next instruction is also OUT.
- `halted` rises at the edge that executes HALT.
- Reset overrides everything, including a simultaneous `run` or `prog_valid`.
- Reset mid-program: registers, memory and the program store all clear. The program must be reloaded.
- An ST followed by an LD of the same address returns the stored value.

## Configuration
- `TRASH_DIV_EN`:
  - Defined: ALU ops 3 (div) and 4 (mod) are implemented. Divide-by-zero gives quotient = all ones and remainder = R[A].
  - Undefined: no divider is synthesised. Ops 3 and 4 leave R[A] unchanged, i.e. they behave as a NOP that still advances `pc`.

## Test plan
- Load LDI R0,5; LDI R1,3; ALU R0+R1; OUT R0; HALT, then raise `run` → `out_data` = 8 with `out_valid` for 1 cycle on the 4th run edge, `halted` = 1 on the 5th, `pc` = 4.
- LDI R2,0xAA; ST R2→M[9]; LD M[9]→R3; OUT R3 → `out_data` = 0xAA.
- Countdown loop: LDI R0,3; LDI R1,0; OUT R0; ALU dec R0; JNE R0,R1→2; HALT → out_valid pulses with values 3, 2, 1, then `halted` = 1.
- Program PDEPTH NOPs, run for 2·PDEPTH cycles → `pc` wraps to 0 twice and `halted` stays 0. Then drop `run` → `pc` = 0 next cycle and a reload writes starting at word 0.
- With `TRASH_DIV_EN`: 13 div 4 = 3, 13 mod 4 = 1, 7 div 0 = 0xFF. Without it: R[A] is unchanged.
- Pulse `rst_n` low mid-run → every output, register and memory word reads 0 and the state is LOAD.

Source files
------------

// File: rtl/trash_cpu.sv
// trash_cpu: parametrised single-cycle toy processor with a loadable program store,
// register file, data memory and integrated ALU.
//
// Ports:
//   clk_i        - clock, all state updates on the rising edge
//   rst_ni       - synchronous active-low reset
//   run_i        - 0 = programming mode, 1 = execution mode
//   prog_valid_i - in programming mode, write prog_data_i to the program store
//   prog_data_i  - 16-bit instruction word to load
//   out_data_o   - last value emitted by an OUT instruction
//   out_valid_o  - one-cycle pulse when out_data_o updates
//   pc_o         - current program counter
//   halted_o     - high while halted
//
// Build option: define TRASH_DIV_EN to implement ALU div (3) and mod (4); otherwise those
// ALU ops leave the destination unchanged.
module trash_cpu #(
  parameter int unsigned DW     = 8,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned PDEPTH = 8,
  parameter int unsigned MDEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      run_i,
  input  logic                      prog_valid_i,
  input  logic [15:0]               prog_data_i,
  output logic [DW-1:0]             out_data_o,
  output logic                      out_valid_o,
  output logic [$clog2(PDEPTH)-1:0] pc_o,
  output logic                      halted_o
);
  localparam int unsigned RAW = $clog2(NREGS);
  localparam int unsigned PAW = $clog2(PDEPTH);
  localparam int unsigned MAW = $clog2(MDEPTH);

  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAlu  = 4'h2;
  localparam logic [3:0] OpSt   = 4'h3;
  localparam logic [3:0] OpLd   = 4'h4;
  localparam logic [3:0] OpJmp  = 4'h5;
  localparam logic [3:0] OpJeq  = 4'h6;
  localparam logic [3:0] OpJne  = 4'h7;
  localparam logic [3:0] OpOut  = 4'h8;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

  state_e         state_q, state_d;
  logic [15:0]    prog_q [PDEPTH];
  logic [DW-1:0]  regs_q [NREGS];
  logic [DW-1:0]  mem_q  [MDEPTH];
  logic [PAW-1:0] pc_q, pc_d, lptr_q;
  logic [DW-1:0]  out_data_q;
  logic           out_valid_q;

  // Instruction decode
  logic [15:0]    instr;
  logic [3:0]     op, fc;
  logic [RAW-1:0] ra, rb;
  logic [7:0]     imm;
  logic [MAW-1:0] maddr;
  logic [PAW-1:0] jtgt;
  logic [DW-1:0]  a, b;
  logic           unused_instr;

  assign instr        = prog_q[pc_q];
  assign op           = instr[15:12];
  assign ra           = instr[8 +: RAW];
  assign rb           = instr[4 +: RAW];
  assign fc           = instr[3:0];
  assign imm          = instr[7:0];
  assign maddr        = instr[MAW-1:0];
  assign jtgt         = instr[PAW-1:0];
  assign a            = regs_q[ra];
  assign b            = regs_q[rb];
  assign unused_instr = ^instr;

  logic exec, load_we;

  // ALU
  logic [DW-1:0] alu_res;
  logic          alu_we;

  always_comb begin
    alu_res = a;
    alu_we  = 1'b1;
    unique case (fc)
      4'h0: alu_res = a + b;
      4'h1: alu_res = a - b;
      4'h2: alu_res = a * b;
`ifdef TRASH_DIV_EN
      4'h3: alu_res = (b == '0) ? '1 : a / b;
      4'h4: alu_res = (b == '0) ? a : a % b;
`else
      4'h3, 4'h4: alu_we = 1'b0;
`endif
      4'h5: alu_res = a & b;
      4'h6: alu_res = a | b;
      4'h7: alu_res = a ^ b;
      4'h8: alu_res = ~a;
      4'h9: alu_res = a << 1;
      4'hA: alu_res = a >> 1;
      4'hB: alu_res = a + DW'(1);
      4'hC: alu_res = a - DW'(1);
      4'hD: alu_res = (a < b) ? a : b;
      4'hE: alu_res = (a > b) ? a : b;
      4'hF: alu_res = b;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Leaving LOAD executes P[0] on the same edge, so LOAD and RUN share it.
  always_comb begin
    state_d = state_q;
    if (!run_i) begin
      state_d = StLoad;
    end else if (state_q != StHalt) begin
      state_d = (op == OpHalt) ? StHalt : StRun;
    end
  end

  // FSM: outputs / control strobes
  always_comb begin
    halted_o = (state_q == StHalt);
    exec     = run_i && (state_q != StHalt);
    load_we  = !run_i && (state_q == StLoad) && prog_valid_i;
  end

  // Next pc
  always_comb begin
    pc_d = pc_q;
    if (!run_i) begin
      pc_d = '0;
    end else if (exec) begin
      case (op)
        OpJmp:   pc_d = jtgt;
        OpJeq:   pc_d = (a == b) ? jtgt : pc_q + PAW'(1);
        OpJne:   pc_d = (a != b) ? jtgt : pc_q + PAW'(1);
        OpHalt:  pc_d = pc_q;
        default: pc_d = pc_q + PAW'(1);
      endcase
    end
  end

  // Register file / memory write strobes
  logic          rf_we, mem_we;
  logic [DW-1:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    mem_we   = 1'b0;
    rf_wdata = alu_res;
    if (exec) begin
      case (op)
        OpLdi: begin
          rf_we    = 1'b1;
          rf_wdata = DW'(imm);
        end
        OpAlu: rf_we = alu_we;
        OpLd: begin
          rf_we    = 1'b1;
          rf_wdata = mem_q[maddr];
        end
        OpSt:    mem_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q        <= '0;
      lptr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= exec && (op == OpOut);
      if (exec && (op == OpOut)) begin
        out_data_q <= a;
      end
      if (load_we) begin
        lptr_q <= lptr_q + PAW'(1);
      end else if (!run_i && (state_q != StLoad)) begin
        lptr_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prog_q <= '{default: '0};
      regs_q <= '{default: '0};
      mem_q  <= '{default: '0};
    end else begin
      if (load_we) begin
        prog_q[lptr_q] <= prog_data_i;
      end
      if (rf_we) begin
        regs_q[ra] <= rf_wdata;
      end
      if (mem_we) begin
        mem_q[maddr] <= a;
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign pc_o        = pc_q;

endmodule

// File: tb/tb_trash_cpu.sv
// Self-checking bench for trash_cpu: directed programs plus a random stream of mode,
// load and run cycles, checked against an instruction-level reference model.
module tb_trash_cpu;
  localparam int DW     = 8;
  localparam int NREGS  = 4;
  localparam int PDEPTH = 8;
  localparam int MDEPTH = 16;
  localparam int MASK   = (1 << DW) - 1;
`ifdef TRASH_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      run = 1'b0;
  logic                      prog_valid = 1'b0;
  logic [15:0]               prog_data = '0;
  logic [DW-1:0]             out_data;
  logic                      out_valid;
  logic [$clog2(PDEPTH)-1:0] pc;
  logic                      halted;

  trash_cpu #(
    .DW    (DW),
    .NREGS (NREGS),
    .PDEPTH(PDEPTH),
    .MDEPTH(MDEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .run_i       (run),
    .prog_valid_i(prog_valid),
    .prog_data_i (prog_data),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .pc_o        (pc),
    .halted_o    (halted)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int val;
    int edge_n;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: architectural state of the machine
  int m_prog[PDEPTH];
  int m_reg[NREGS];
  int m_mem[MDEPTH];
  int m_pc, m_lptr, m_out;
  bit m_halted, m_inload;

  function automatic void model_reset();
    foreach (m_prog[i]) m_prog[i] = 0;
    foreach (m_reg[i]) m_reg[i] = 0;
    foreach (m_mem[i]) m_mem[i] = 0;
    m_pc = 0;
    m_lptr = 0;
    m_out = 0;
    m_halted = 1'b0;
    m_inload = 1'b1;
  endfunction

  function automatic int alu(input int f, input int x, input int y);
    longint r;
    case (f)
      0: r = x + y;
      1: r = x - y;
      2: r = longint'(x) * y;
      3: r = (y == 0) ? MASK : x / y;
      4: r = (y == 0) ? x : x % y;
      5: r = x & y;
      6: r = x | y;
      7: r = x ^ y;
      8: r = ~x;
      9: r = x * 2;
      10: r = x / 2;
      11: r = x + 1;
      12: r = x - 1;
      13: r = (x < y) ? x : y;
      14: r = (x > y) ? x : y;
      default: r = y;
    endcase
    return int'(r & MASK);
  endfunction

  // One clock edge of the machine with the given inputs.
  function automatic void model_edge(input bit r, input bit pv, input int data, input int edge_n);
    int ins, op, ra, rb, c, imm, x, y, nxt;
    if (!r) begin
      if (m_inload && pv) begin
        m_prog[m_lptr] = data;
        m_lptr = (m_lptr + 1) % PDEPTH;
      end else if (!m_inload) begin
        m_lptr = 0;
      end
      m_inload = 1'b1;
      m_pc = 0;
      m_halted = 1'b0;
      return;
    end
    m_inload = 1'b0;
    if (m_halted) return;
    ins = m_prog[m_pc];
    op  = (ins >> 12) & 15;
    ra  = ((ins >> 8) & 15) % NREGS;
    rb  = ((ins >> 4) & 15) % NREGS;
    c   = ins & 15;
    imm = ins & 255;
    x   = m_reg[ra];
    y   = m_reg[rb];
    nxt = (m_pc + 1) % PDEPTH;
    case (op)
      1: m_reg[ra] = imm & MASK;
      2: if (DIV_EN || (c != 3 && c != 4)) m_reg[ra] = alu(c, x, y);
      3: m_mem[imm % MDEPTH] = x;
      4: m_reg[ra] = m_mem[imm % MDEPTH];
      5: nxt = c % PDEPTH;
      6: if (x == y) nxt = c % PDEPTH;
      7: if (x != y) nxt = c % PDEPTH;
      8: begin
        m_out = x;
        exp_q.push_back('{x, edge_n});
      end
      15: begin
        m_halted = 1'b1;
        nxt = m_pc;
      end
      default: ;
    endcase
    m_pc = nxt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  // Monitor: every out_valid pulse is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_pulse: got %0h at edge %0d, required no pulse", out_data, edge_cnt);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== DW'(e.val) || edge_cnt != e.edge_n) begin
            fails++;
            $display("FAIL out_pulse: got %0h at edge %0d, required %0h at edge %0d",
                     out_data, edge_cnt, e.val, e.edge_n);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // Apply inputs for one edge, step the model, then compare at the following negedge.
  task automatic drive(input bit r, input bit pv, input logic [15:0] d);
    run = r;
    prog_valid = pv;
    prog_data = d;
    model_edge(r, pv, int'(d), edge_cnt + 1);
    @(negedge clk);
    chk("pc", 32'(pc), m_pc);
    chk("halted", 32'(halted), 32'(m_halted));
    chk("out_data", 32'(out_data), m_out);
  endtask

  task automatic do_reset(input bit r, input bit pv);
    rst_n = 1'b0;
    run = r;
    prog_valid = pv;
    prog_data = 16'hF0F0;
    model_reset();
    @(negedge clk);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    rst_n = 1'b1;
  endtask

  logic [15:0] prog[$];

  task automatic load_prog();
    foreach (prog[i]) drive(1'b0, 1'b1, prog[i]);
  endtask

  task automatic run_n(input int n);
    repeat (n) drive(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  initial begin
    bit r;
    @(negedge clk);
    do_reset(1'b1, 1'b1);

    // LDI R0,5; LDI R1,3; R0+=R1; OUT R0; HALT
    prog = '{16'h1005, 16'h1103, 16'h2010, 16'h8000, 16'hF000};
    load_prog();
    run_n(6);
    chk("p1_out", 32'(out_data), 8);
    chk("p1_pc", 32'(pc), 4);
    chk("p1_halted", 32'(halted), 1);
    drive(1'b0, 1'b0, '0);

    // Store then load back through memory
    prog = '{16'h12AA, 16'h3209, 16'h4309, 16'h8300, 16'hF000};
    load_prog();
    run_n(6);
    chk("p2_out", 32'(out_data), 32'hAA);
    drive(1'b0, 1'b0, '0);

    // Countdown loop emitting 3, 2, 1
    prog = '{16'h1003, 16'h1100, 16'h8000, 16'h200C, 16'h7012, 16'hF000};
    load_prog();
    run_n(20);
    chk("loop_out", 32'(out_data), 1);
    chk("loop_pc", 32'(pc), 5);
    chk("loop_halted", 32'(halted), 1);
    drive(1'b0, 1'b0, '0);

    // Full store of NOPs: pc wraps twice without halting
    prog.delete();
    repeat (PDEPTH) prog.push_back(16'h0000);
    load_prog();
    run_n(PDEPTH);
    chk("nop_wrap1_pc", 32'(pc), 0);
    run_n(PDEPTH);
    chk("nop_wrap2_pc", 32'(pc), 0);
    chk("nop_halted", 32'(halted), 0);
    drive(1'b0, 1'b0, '0);
    chk("stop_pc", 32'(pc), 0);
    prog = '{16'h105A, 16'h8000, 16'hF000};
    load_prog();
    run_n(4);
    chk("reload_out", 32'(out_data), 32'h5A);
    chk("reload_pc", 32'(pc), 2);
    drive(1'b0, 1'b0, '0);

    // Divider: 13 div 4, 13 mod 4
    prog = '{16'h100D, 16'h1104, 16'h2013, 16'h8000, 16'h100D, 16'h2014, 16'h8000, 16'hF000};
    load_prog();
    run_n(4);
`ifdef TRASH_DIV_EN
    chk("div_13_4", 32'(out_data), 3);
`else
    chk("div_off", 32'(out_data), 13);
`endif
    run_n(4);
`ifdef TRASH_DIV_EN
    chk("mod_13_4", 32'(out_data), 1);
`else
    chk("mod_off", 32'(out_data), 13);
`endif
    drive(1'b0, 1'b0, '0);
    // 7 div 0
    prog = '{16'h1207, 16'h1300, 16'h2233, 16'h8200, 16'hF000};
    load_prog();
    run_n(6);
`ifdef TRASH_DIV_EN
    chk("div_by_zero", 32'(out_data), 32'hFF);
`else
    chk("div0_off", 32'(out_data), 7);
`endif
    drive(1'b0, 1'b0, '0);

    // Reset mid-run, with run and prog_valid asserted alongside it
    prog = '{16'h1177, 16'h3109, 16'h5001};
    load_prog();
    run_n(5);
    do_reset(1'b1, 1'b1);
    // Read back registers and memory: all must be zero
    prog = '{16'h4009, 16'h8000, 16'h8100, 16'h8200, 16'h8300, 16'h410F, 16'h8100, 16'hF000};
    load_prog();
    run_n(10);
    chk("post_rst_out", 32'(out_data), 0);
    chk("post_rst_halted", 32'(halted), 1);

    // Random mode/load/run stream
    r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) r = ~r;
      drive(r, 1'($urandom_range(0, 1)), 16'($urandom));
    end
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
